// File: rtl/control_mult_div_pkg.sv
`default_nettype none
// ============================================================================
// Module   : control_mult_div_pkg
// Brief    : Shared constants for the HI/LO multiply/divide unit: function
//            codes, FSM state encoding and default operand width.
// Revision : 1.0
// ============================================================================
package control_mult_div_pkg;

    localparam int c_nbits = 32;
    localparam int c_fbits = 6;

    localparam logic [c_fbits-1:0] c_funct_mult  = 6'b011000;
    localparam logic [c_fbits-1:0] c_funct_multu = 6'b011001;
    localparam logic [c_fbits-1:0] c_funct_div   = 6'b011010;
    localparam logic [c_fbits-1:0] c_funct_divu  = 6'b011011;

    typedef logic [1:0] state_t;

    localparam state_t c_st_idle = 2'd0;
    localparam state_t c_st_calc = 2'd1;
    localparam state_t c_st_fix  = 2'd2;
    localparam state_t c_st_done = 2'd3;

    function automatic logic is_md_funct(input logic [c_fbits-1:0] funct);
        return (funct == c_funct_mult) || (funct == c_funct_multu) ||
               (funct == c_funct_div)  || (funct == c_funct_divu);
    endfunction

endpackage
`default_nettype wire

// File: rtl/control_mult_div_cond_negate.sv
`default_nettype none
// ============================================================================
// Module   : cond_negate
// Brief    : Conditional two's-complement negation used to restore result
//            signs after magnitude-only multiply/divide iterations.
// Revision : 1.0
// ============================================================================
module cond_negate #(
    parameter int WIDTH = 32
) (
    input  logic             i_neg,
    input  logic [WIDTH-1:0] i_value,
    output logic [WIDTH-1:0] o_value
);

    assign o_value = i_neg ? ((~i_value) + WIDTH'(1)) : i_value;

endmodule
`default_nettype wire

// File: rtl/control_mult_div.sv
`default_nettype none
// ============================================================================
// Module   : control_mult_div
// Brief    : Iterative MULT/MULTU/DIV/DIVU unit writing the HI/LO registers,
//            one shift-add or shift-subtract step per cycle.
// Revision : 1.0
// ============================================================================
module control_mult_div
    import control_mult_div_pkg::*;
#(
    parameter int NBITS = c_nbits,
    parameter int FBITS = c_fbits
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_Start,
    input  logic [FBITS-1:0] i_Funct,
    input  logic [NBITS-1:0] i_RS,
    input  logic [NBITS-1:0] i_RT,
    output logic             o_Busy,
    output logic             o_Done,
    output logic [NBITS-1:0] o_HI,
    output logic [NBITS-1:0] o_LO
);

    localparam int CNT_W = (NBITS > 1) ? $clog2(NBITS) : 1;
    localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(NBITS - 1);

    state_t r_state;
    state_t w_state_next;

    logic [CNT_W-1:0]   r_cnt;
    logic               r_is_div;
    logic               r_neg_res;
    logic               r_neg_rem;
    logic               r_div_zero;
    logic [NBITS-1:0]   r_mcand;
    logic [NBITS-1:0]   r_rs_raw;
    logic [NBITS-1:0]   r_hi;
    logic [NBITS-1:0]   r_lo;
    logic [NBITS-1:0]   r_hi_out;
    logic [NBITS-1:0]   r_lo_out;

    logic [c_fbits-1:0] w_funct;
    logic               w_launch;
    logic               w_op_div;
    logic               w_op_signed;
    logic               w_rs_neg;
    logic               w_rt_neg;
    logic [NBITS-1:0]   w_rs_mag;
    logic [NBITS-1:0]   w_rt_mag;
    logic [NBITS:0]     w_mul_sum;
    logic [NBITS:0]     w_div_shift;
    logic               w_div_ge;
    logic [NBITS-1:0]   w_div_diff;
    logic [2*NBITS-1:0] w_prod_fix;
    logic [NBITS-1:0]   w_quot_fix;
    logic [NBITS-1:0]   w_rem_fix;
    logic [NBITS-1:0]   w_fix_hi;
    logic [NBITS-1:0]   w_fix_lo;

    // Launch decode: operands are reduced to magnitudes up front so the
    // iteration datapath is purely unsigned.
    assign w_funct     = c_fbits'(i_Funct);
    assign w_launch    = (r_state == c_st_idle) && i_Start && is_md_funct(w_funct);
    assign w_op_div    = (w_funct == c_funct_div)  || (w_funct == c_funct_divu);
    assign w_op_signed = (w_funct == c_funct_mult) || (w_funct == c_funct_div);
    assign w_rs_neg    = w_op_signed && i_RS[NBITS-1];
    assign w_rt_neg    = w_op_signed && i_RT[NBITS-1];
    assign w_rs_mag    = w_rs_neg ? ((~i_RS) + NBITS'(1)) : i_RS;
    assign w_rt_mag    = w_rt_neg ? ((~i_RT) + NBITS'(1)) : i_RT;

    assign w_mul_sum   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_mcand} : '0);
    assign w_div_shift = {r_hi, r_lo[NBITS-1]};
    assign w_div_ge    = (w_div_shift >= {1'b0, r_mcand});
    // Only used when the shifted remainder is >= divisor, so the true
    // difference always fits in NBITS.
    assign w_div_diff  = w_div_shift[NBITS-1:0] - r_mcand;

    cond_negate #(.WIDTH(2*NBITS)) u_neg_prod (
        .i_neg   (r_neg_res),
        .i_value ({r_hi, r_lo}),
        .o_value (w_prod_fix)
    );

    cond_negate #(.WIDTH(NBITS)) u_neg_quot (
        .i_neg   (r_neg_res),
        .i_value (r_lo),
        .o_value (w_quot_fix)
    );

    cond_negate #(.WIDTH(NBITS)) u_neg_rem (
        .i_neg   (r_neg_rem),
        .i_value (r_hi),
        .o_value (w_rem_fix)
    );

    always_comb begin
        w_fix_hi = w_prod_fix[2*NBITS-1:NBITS];
        w_fix_lo = w_prod_fix[NBITS-1:0];
        if (r_is_div) begin
            if (r_div_zero) begin
                w_fix_hi = r_rs_raw;
                w_fix_lo = '1;
            end else begin
                w_fix_hi = w_rem_fix;
                w_fix_lo = w_quot_fix;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        o_Busy       = 1'b0;
        o_Done       = 1'b0;
        case (r_state)
            c_st_idle: begin
                if (w_launch) begin
                    w_state_next = c_st_calc;
                end
            end
            c_st_calc: begin
                o_Busy = 1'b1;
                if (r_cnt == c_cnt_last) begin
                    w_state_next = c_st_fix;
                end
            end
            c_st_fix: begin
                o_Busy       = 1'b1;
                w_state_next = c_st_done;
            end
            c_st_done: begin
                o_Done       = 1'b1;
                w_state_next = c_st_idle;
            end
            default: begin
                w_state_next = c_st_idle;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_cnt      <= '0;
            r_is_div   <= 1'b0;
            r_neg_res  <= 1'b0;
            r_neg_rem  <= 1'b0;
            r_div_zero <= 1'b0;
            r_mcand    <= '0;
            r_rs_raw   <= '0;
            r_hi       <= '0;
            r_lo       <= '0;
            r_hi_out   <= '0;
            r_lo_out   <= '0;
        end else begin
            if (w_launch) begin
                r_cnt      <= '0;
                r_is_div   <= w_op_div;
                r_neg_res  <= w_rs_neg ^ w_rt_neg;
                r_neg_rem  <= w_rs_neg;
                r_div_zero <= w_op_div && (i_RT == '0);
                r_mcand    <= w_rt_mag;
                r_rs_raw   <= i_RS;
                r_hi       <= '0;
                r_lo       <= w_rs_mag;
            end else if (r_state == c_st_calc) begin
                r_cnt <= (r_cnt == c_cnt_last) ? '0 : r_cnt + CNT_W'(1);
                if (r_is_div) begin
                    r_hi <= w_div_ge ? w_div_diff : w_div_shift[NBITS-1:0];
                    r_lo <= {r_lo[NBITS-2:0], w_div_ge};
                end else begin
                    r_hi <= w_mul_sum[NBITS:1];
                    r_lo <= {w_mul_sum[0], r_lo[NBITS-1:1]};
                end
            end
            if (r_state == c_st_fix) begin
                r_hi_out <= w_fix_hi;
                r_lo_out <= w_fix_lo;
            end
        end
    end

    assign o_HI = r_hi_out;
    assign o_LO = r_lo_out;

endmodule
`default_nettype wire
